// File: rtl/comp_mode_ctrl_if.sv
// Front-panel bundle for the competition-mode controller: raw buttons,
// sub-mode display/LED sources in; arbitrated display, LEDs and pulses out.
interface comp_mode_ctrl_if;
  logic         btn_confirm;
  logic         btn_select;
  logic         btn_exit;
  logic [2:0]   mode_busy;
  logic [191:0] seg_in_flat;
  logic [47:0]  led_in_flat;
  logic [2:0]   mode_sel;
  logic         mode_active;
  logic         confirm_pulse;
  logic         select_pulse;
  logic         exit_pulse;
  logic [7:0]   Seg1;
  logic [7:0]   Seg2;
  logic [7:0]   anode;
  logic [7:0]   led1;
  logic [7:0]   led2;

  modport master (
    output btn_confirm, btn_select, btn_exit, mode_busy, seg_in_flat, led_in_flat,
    input  mode_sel, mode_active, confirm_pulse, select_pulse, exit_pulse,
    input  Seg1, Seg2, anode, led1, led2
  );

  modport slave (
    input  btn_confirm, btn_select, btn_exit, mode_busy, seg_in_flat, led_in_flat,
    output mode_sel, mode_active, confirm_pulse, select_pulse, exit_pulse,
    output Seg1, Seg2, anode, led1, led2
  );
endinterface

// File: rtl/comp_mode_ctrl.sv
// Competition-mode top: button debounce, MENU/ACTIVE mode FSM, front-panel
// arbitration between the three sub-modes and 8-digit multiplexed scan.
module comp_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 2_000_000,
  parameter int unsigned SCAN_DIV     = 10_000
) (
  input logic             clk,
  input logic             reset,
  comp_mode_ctrl_if.slave bus
);
  localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [0:0]  S_MENU   = 1'b0;
  localparam logic [0:0]  S_ACTIVE = 1'b1;

  // Button index: 0 confirm, 1 select, 2 exit
  logic [2:0]    w_btn;
  logic [2:0]    r_sync1, r_sync2, r_lvl;
  logic [CW-1:0] r_cnt [3];
  logic [2:0]    w_ev;

  logic [0:0]    r_state;
  logic [2:0]    r_sel;
  logic          r_cp, r_sp, r_ep;
  logic          w_busy;
  logic          w_sel_ok;
  logic [1:0]    w_idx;
  logic [7:0]    w_glyph;

  logic [7:0]    r_pat [8];
  logic [7:0]    r_led1, r_led2;
  logic [SW-1:0] r_div;
  logic [2:0]    r_dig;
  logic [2:0]    w_dig_nxt;
  logic [7:0]    r_anode, r_seg1, r_seg2;

  assign w_btn = {bus.btn_exit, bus.btn_select, bus.btn_confirm};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_lvl   <= '0;
      for (int unsigned i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      for (int unsigned i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_lvl[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(DEBOUNCE_CYC - 1)) begin
          r_cnt[i] <= '0;
          r_lvl[i] <= r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Event fires in the same cycle the accepted level is updated to 1
  always_comb begin
    w_ev = '0;
    for (int unsigned i = 0; i < 3; i++)
      w_ev[i] = r_sync2[i] & ~r_lvl[i] & (r_cnt[i] == CW'(DEBOUNCE_CYC - 1));
  end

  assign w_busy   = |(bus.mode_busy & r_sel);
  assign w_sel_ok = (r_sel == 3'b001) || (r_sel == 3'b010) || (r_sel == 3'b100);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_MENU;
      r_sel   <= 3'b001;
      r_cp    <= 1'b0;
      r_sp    <= 1'b0;
      r_ep    <= 1'b0;
    end else begin
      r_cp <= 1'b0;
      r_sp <= 1'b0;
      r_ep <= 1'b0;
      case (r_state)
        S_MENU: begin
          if (w_ev[0])       r_state <= S_ACTIVE;
          if (!w_sel_ok)     r_sel   <= 3'b001;
          else if (!w_ev[0] && w_ev[1]) r_sel <= {r_sel[1:0], r_sel[2]};
        end
        S_ACTIVE: begin
          r_cp <= w_ev[0];
          r_sp <= w_ev[1];
          r_ep <= w_ev[2];
          if (w_ev[2] && !w_busy) r_state <= S_MENU;
        end
        default: r_state <= S_MENU;
      endcase
    end
  end

  always_comb begin
    w_idx   = 2'd0;
    w_glyph = 8'b0110_0000;
    case (r_sel)
      3'b010:  begin w_idx = 2'd1; w_glyph = 8'b1101_1010; end
      3'b100:  begin w_idx = 2'd2; w_glyph = 8'b1111_0010; end
      default: begin w_idx = 2'd0; w_glyph = 8'b0110_0000; end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned d = 0; d < 8; d++) r_pat[d] <= '0;
      r_led1 <= '0;
      r_led2 <= '0;
    end else if (r_state == S_ACTIVE) begin
      for (int unsigned d = 0; d < 8; d++)
        r_pat[d] <= bus.seg_in_flat[int'(w_idx) * 64 + d * 8 +: 8];
      r_led1 <= bus.led_in_flat[int'(w_idx) * 16 +: 8];
      r_led2 <= bus.led_in_flat[int'(w_idx) * 16 + 8 +: 8];
    end else begin
      r_pat[0] <= w_glyph;
      for (int unsigned d = 1; d < 8; d++) r_pat[d] <= '0;
      r_led1 <= '0;
      r_led2 <= '0;
    end
  end

  // Anode and segment flops are loaded from the next digit so they stay aligned
  assign w_dig_nxt = (r_div == SW'(SCAN_DIV - 1)) ? r_dig + 3'd1 : r_dig;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div   <= '0;
      r_dig   <= '0;
      r_anode <= 8'b0000_0001;
      r_seg1  <= '0;
      r_seg2  <= '0;
    end else begin
      r_div   <= (r_div == SW'(SCAN_DIV - 1)) ? '0 : r_div + SW'(1);
      r_dig   <= w_dig_nxt;
      r_anode <= 8'b0000_0001 << w_dig_nxt;
      r_seg1  <= w_dig_nxt[2] ? 8'h00 : r_pat[w_dig_nxt];
      r_seg2  <= w_dig_nxt[2] ? r_pat[w_dig_nxt] : 8'h00;
    end
  end

  assign bus.mode_sel      = r_sel;
  assign bus.mode_active   = (r_state == S_ACTIVE);
  assign bus.confirm_pulse = r_cp;
  assign bus.select_pulse  = r_sp;
  assign bus.exit_pulse    = r_ep;
  assign bus.Seg1          = r_seg1;
  assign bus.Seg2          = r_seg2;
  assign bus.anode         = r_anode;
  assign bus.led1          = r_led1;
  assign bus.led2          = r_led2;
endmodule

// File: tb/tb_comp_mode_ctrl.sv
// Bench for comp_mode_ctrl: directed plan steps followed by random button
// traffic, compared against a press-level model of the menu/active behaviour.
module tb_comp_mode_ctrl;
  localparam int unsigned DEB  = 4;
  localparam int unsigned SDIV = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  comp_mode_ctrl_if bus ();

  comp_mode_ctrl #(.DEBOUNCE_CYC(DEB), .SCAN_DIV(SDIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  int n_cp = 0, n_sp = 0, n_ep = 0;
  always @(negedge clk) begin
    if (bus.confirm_pulse === 1'b1) n_cp++;
    if (bus.select_pulse  === 1'b1) n_sp++;
    if (bus.exit_pulse    === 1'b1) n_ep++;
  end

  int m_sel = 0;
  bit m_act = 1'b0;
  int e_cp = 0, e_sp = 0, e_ep = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] glyph(input int n);
    case (n)
      1:       return 8'b1101_1010;
      2:       return 8'b1111_0010;
      default: return 8'b0110_0000;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int d);
    if (!m_act) return (d == 0) ? glyph(m_sel) : 8'h00;
    return bus.seg_in_flat[m_sel * 64 + d * 8 +: 8];
  endfunction

  // A press held for at least DEB synchronized cycles is one event
  task automatic press(input bit c, input bit s, input bit e, input int hold);
    if (hold >= int'(DEB)) begin
      if (!m_act) begin
        if (c) m_act = 1'b1;
        else if (s) m_sel = (m_sel + 1) % 3;
      end else begin
        if (c) e_cp++;
        if (s) e_sp++;
        if (e) begin
          e_ep++;
          if (!bus.mode_busy[m_sel]) m_act = 1'b0;
        end
      end
    end
    bus.btn_confirm = c;
    bus.btn_select  = s;
    bus.btn_exit    = e;
    cyc(hold);
    bus.btn_confirm = 1'b0;
    bus.btn_select  = 1'b0;
    bus.btn_exit    = 1'b0;
    cyc(DEB + 8);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".sel"}, bus.mode_sel, 3'b001 << m_sel);
    chk({tag, ".active"}, bus.mode_active, m_act);
    chk({tag, ".n_confirm"}, n_cp, e_cp);
    chk({tag, ".n_select"}, n_sp, e_sp);
    chk({tag, ".n_exit"}, n_ep, e_ep);
  endtask

  task automatic check_disp(input string tag);
    logic [7:0] a;
    chk({tag, ".led1"}, bus.led1, m_act ? bus.led_in_flat[m_sel * 16 +: 8] : 8'h00);
    chk({tag, ".led2"}, bus.led2, m_act ? bus.led_in_flat[m_sel * 16 + 8 +: 8] : 8'h00);
    for (int d = 0; d < 8; d++) begin
      int k;
      a = 8'd1 << d;
      k = 0;
      while (bus.anode !== a && k < 40) begin
        cyc(1);
        k++;
      end
      chk({tag, ".anode"}, bus.anode, a);
      chk({tag, ".seg1"}, bus.Seg1, (d < 4) ? exp_seg(d) : 8'h00);
      chk({tag, ".seg2"}, bus.Seg2, (d >= 4) ? exp_seg(d) : 8'h00);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.btn_confirm = 1'b0;
    bus.btn_select  = 1'b0;
    bus.btn_exit    = 1'b0;
    bus.mode_busy   = 3'b000;
    bus.seg_in_flat = '0;
    bus.led_in_flat = '0;

    // Reset values and free-running scan
    cyc(2);
    chk("rst.anode", bus.anode, 8'h01);
    chk("rst.seg1", bus.Seg1, 8'h00);
    chk("rst.seg2", bus.Seg2, 8'h00);
    chk("rst.led1", bus.led1, 8'h00);
    check_state("rst");
    reset = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      int dg;
      cyc(1);
      dg = (k / int'(SDIV)) % 8;
      chk("scan.anode", bus.anode, 8'd1 << dg);
      if (k >= 3) begin
        chk("scan.seg1", bus.Seg1, (dg == 0) ? 8'b0110_0000 : 8'h00);
        chk("scan.seg2", bus.Seg2, 8'h00);
      end
    end

    // Menu rotation, glitch rejection
    press(0, 1, 0, 10);
    check_state("sel1");
    press(0, 1, 0, 10);
    check_state("sel2");
    check_disp("menu2");
    press(0, 1, 0, 2);
    check_state("glitch2");
    press(0, 1, 0, DEB - 1);
    check_state("glitch_edge");
    press(0, 0, 1, 10);
    check_state("menu_exit");

    // Enter mode 010 and check its display slice
    press(0, 1, 0, 10);
    press(0, 1, 0, 10);
    check_state("back_to_1");
    bus.seg_in_flat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.seg_in_flat[64 + 5 * 8 +: 8] = 8'hAB;
    bus.led_in_flat = {$urandom, $urandom};
    bus.led_in_flat[16 +: 8] = 8'h5A;
    press(1, 0, 0, 10);
    check_state("enter");
    check_disp("active1");

    // Exit while busy stays, exit while idle returns
    bus.mode_busy = 3'b010;
    press(0, 0, 1, 10);
    check_state("exit_busy");
    bus.mode_busy = 3'b000;
    press(0, 0, 1, 10);
    check_state("exit_idle");
    check_disp("menu_after");

    // Simultaneous confirm and select
    press(1, 1, 0, 10);
    check_state("c_and_s");
    press(0, 0, 1, 10);
    check_state("c_and_s_out");

    for (int it = 0; it < 40; it++) begin
      int combo, hold;
      bus.seg_in_flat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.led_in_flat = {$urandom, $urandom};
      bus.mode_busy   = 3'($urandom_range(0, 7));
      combo = $urandom_range(1, 7);
      hold  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, DEB - 1)
                                          : $urandom_range(DEB + 2, DEB + 8);
      press(combo[0], combo[1], combo[2], hold);
      check_state("rand");
      if (it % 4 == 0) check_disp("rand");
    end

    // Async reset while ACTIVE in mode 100
    bus.mode_busy = 3'b000;
    if (m_act) press(0, 0, 1, 10);
    while (m_sel != 2) press(0, 1, 0, 10);
    press(1, 0, 0, 10);
    check_state("pre_rst");
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    m_act = 1'b0;
    m_sel = 0;
    chk("arst.active", bus.mode_active, 1'b0);
    chk("arst.sel", bus.mode_sel, 3'b001);
    chk("arst.anode", bus.anode, 8'h01);
    chk("arst.cp", bus.confirm_pulse, 1'b0);
    chk("arst.sp", bus.select_pulse, 1'b0);
    chk("arst.ep", bus.exit_pulse, 1'b0);
    chk("arst.led1", bus.led1, 8'h00);
    cyc(2);
    reset = 1'b1;
    cyc(4);
    check_state("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
